// File: rtl/dport_tcm_responder.sv
// ---------------------------------------------------------------------------
// dport_tcm_responder
//
// Tightly-coupled data RAM that answers a cached-CPU style data port.
// Every request the port takes is answered by exactly one ack, LATENCY
// cycles later, in strict request order. The RAM is read and written at the
// edge that takes the request. Responses then travel a shift pipeline of
// LATENCY stages to the ack outputs.
//
// Configuration macro:
//   DPORT_STALL_EN  when defined, a 16-bit Fibonacci LFSR (taps 16,14,13,11,
//                   seeded 16'hACE1 in reset) drives pseudo-random accept
//                   stalls. When undefined, accept is held high after reset.
//
// Parameters:
//   BASE_ADDR  byte address of RAM word 0
//   ADDR_W     word-address bits (window is 4*2^ADDR_W bytes)
//   LATENCY    accept-to-ack cycles, legal range 1..4
//
// Ports:
//   clk_i               clock, all state updates on the rising edge
//   rst_ni              asynchronous active-low reset
//   mem_d_addr_i        request byte address (bits [1:0] ignored)
//   mem_d_data_wr_i     write data
//   mem_d_rd_i          read request
//   mem_d_wr_i          byte write strobes
//   mem_d_cacheable_i   ignored
//   mem_d_req_tag_i     request tag
//   mem_d_invalidate_i  cache-maintenance request
//   mem_d_writeback_i   cache-maintenance request
//   mem_d_flush_i       cache-maintenance request
//   mem_d_accept_o      request is taken on this edge when high (registered)
//   mem_d_ack_o         single-cycle response valid
//   mem_d_data_rd_o     read data, zero when ack is low
//   mem_d_error_o       out-of-range error, zero when ack is low
//   mem_d_resp_tag_o    echoed request tag, zero when ack is low
//
// The task write() gives benches backdoor access to the RAM array. It is
// never called from inside the design.
// ---------------------------------------------------------------------------
module dport_tcm_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          ADDR_W    = 12,
  parameter int          LATENCY   = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] mem_d_addr_i,
  input  logic [31:0] mem_d_data_wr_i,
  input  logic        mem_d_rd_i,
  input  logic [3:0]  mem_d_wr_i,
  input  logic        mem_d_cacheable_i,
  input  logic [10:0] mem_d_req_tag_i,
  input  logic        mem_d_invalidate_i,
  input  logic        mem_d_writeback_i,
  input  logic        mem_d_flush_i,
  output logic        mem_d_accept_o,
  output logic        mem_d_ack_o,
  output logic [31:0] mem_d_data_rd_o,
  output logic        mem_d_error_o,
  output logic [10:0] mem_d_resp_tag_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [31:0]              r_mem [DEPTH];
  logic                     r_accept;
  logic [LATENCY-1:0]       r_vld;
  logic [LATENCY-1:0][10:0] r_tag;
  logic [LATENCY-1:0][31:0] r_data;
  logic [LATENCY-1:0]       r_err;

  logic                     w_is_wr;
  logic                     w_is_rd;
  logic                     w_is_req;
  logic                     w_take;
  logic [31:0]              w_offset;
  logic                     w_in_range;
  logic [ADDR_W-1:0]        w_word;
  logic [31:0]              w_rsp_data;
  logic                     w_rsp_err;
  logic                     w_unused;

  assign w_unused = mem_d_cacheable_i;

  // Request decode. Any nonzero strobe makes the access a write, even if rd
  // is also high. The range test uses unsigned wrap-around: addresses below
  // BASE_ADDR give a huge offset and fall out of the window.
  always_comb begin
    w_is_wr    = |mem_d_wr_i;
    w_is_rd    = mem_d_rd_i & ~w_is_wr;
    w_is_req   = mem_d_rd_i | w_is_wr | mem_d_invalidate_i |
                 mem_d_writeback_i | mem_d_flush_i;
    w_take     = w_is_req & r_accept;
    w_offset   = mem_d_addr_i - BASE_ADDR;
    w_in_range = ((w_offset >> (ADDR_W + 2)) == 32'd0);
    w_word     = w_offset[ADDR_W+1:2];
    w_rsp_err  = (w_is_wr | w_is_rd) & ~w_in_range;
    w_rsp_data = (w_is_rd & w_in_range) ? r_mem[w_word] : 32'd0;
  end

  // RAM byte writes at the accept edge. Contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (w_take && w_is_wr && w_in_range) begin
      for (int k = 0; k < 4; k++) begin
        if (mem_d_wr_i[k]) begin
          r_mem[w_word][8*k +: 8] <= mem_d_data_wr_i[8*k +: 8];
        end
      end
    end
  end

  // Response shift pipeline. Stages that carry no response hold zeros, so
  // the last stage drives data/error/tag low whenever ack is low without
  // extra output gating. Reset flushes everything in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_vld  <= '0;
      r_tag  <= '0;
      r_data <= '0;
      r_err  <= '0;
    end else begin
      r_vld[0]  <= w_take;
      r_tag[0]  <= w_take ? mem_d_req_tag_i : 11'd0;
      r_data[0] <= w_take ? w_rsp_data : 32'd0;
      r_err[0]  <= w_take & w_rsp_err;
      for (int s = 1; s < LATENCY; s++) begin
        r_vld[s]  <= r_vld[s-1];
        r_tag[s]  <= r_tag[s-1];
        r_data[s] <= r_data[s-1];
        r_err[s]  <= r_err[s-1];
      end
    end
  end

`ifdef DPORT_STALL_EN
  logic [15:0] r_lfsr;
  logic [15:0] w_lfsr_next;

  // Right-shifting Fibonacci form of taps 16,14,13,11. Accept is loaded
  // from the next LFSR value, so after the first edge it always equals
  // ~r_lfsr[0]; the seed makes that first value 1.
  always_comb begin
    w_lfsr_next = {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lfsr   <= 16'hACE1;
      r_accept <= 1'b0;
    end else begin
      r_lfsr   <= w_lfsr_next;
      r_accept <= ~w_lfsr_next[0];
    end
  end
`else
  // Without stalls, accept rises on the first edge after reset and stays.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_accept <= 1'b0;
    end else begin
      r_accept <= 1'b1;
    end
  end
`endif

  assign mem_d_accept_o   = r_accept;
  assign mem_d_ack_o      = r_vld[LATENCY-1];
  assign mem_d_data_rd_o  = r_data[LATENCY-1];
  assign mem_d_error_o    = r_err[LATENCY-1];
  assign mem_d_resp_tag_o = r_tag[LATENCY-1];

  // Backdoor RAM load for benches.
  task automatic write(input logic [ADDR_W-1:0] word_index,
                       input logic [31:0]       byte_data);
    r_mem[word_index] <= byte_data;
  endtask

endmodule
